stack_pointer_unit: RTL and testbench
=====================================

// Module: stack_pointer_unit
// PURPOSE
//  - Stack pointer for the RAT MCU.
//  - Holds the current SP and tracks how many entries are on the stack.
//  - Produces SP_OUT, which feeds the register-file write-select mux as source 2'b10.
//  - Produces SP_OUT_B (SP-1), which is the scratch RAM address for a PUSH.
//  - Raises FULL/EMPTY status and sticky overflow/underflow/illegal-command flags.
// PARAMETERS
//  - WIDTH      8      SP width; the stack holds up to 2**WIDTH entries.
//  - RESET_VAL  8'h00  SP value on reset; the first push lands at RESET_VAL-1.
// PORTS
//  - CLK       in   1        rising-edge clock
//  - RST_N     in   1        asynchronous, active-low reset
//  - SP_LD     in   1        load SP from DIN and clear the depth count
//  - SP_DECR   in   1        push: SP <= SP-1, depth+1
//  - SP_INCR   in   1        pop: SP <= SP+1, depth-1
//  - CLR_ERR   in   1        clear the OVF, UDF and ILL flags
//  - DIN       in   WIDTH    load value, from the register file DX output
//  - SP_OUT    out  WIDTH    registered SP
//  - SP_OUT_B  out  WIDTH    SP_OUT-1 modulo 2**WIDTH, combinational
//  - DEPTH     out  WIDTH+1  number of entries on the stack, 0..2**WIDTH
//  - FULL      out  1        DEPTH == 2**WIDTH
//  - EMPTY     out  1        DEPTH == 0
//  - OVF       out  1        sticky: push attempted while FULL
//  - UDF       out  1        sticky: pop attempted while EMPTY
//  - ILL       out  1        sticky: SP_INCR and SP_DECR asserted in the same cycle
// BEHAVIOUR
//  - Reset (RST_N low, asynchronous, any time, including mid-sequence):
//    - SP_OUT=RESET_VAL, DEPTH=0, OVF=UDF=ILL=0.
//    - Outputs follow immediately: EMPTY=1, FULL=0, SP_OUT_B=RESET_VAL-1.
//  - Latency:
//    - Commands are sampled on the rising edge of CLK.
//    - SP_OUT and DEPTH change at that edge.
//    - SP_OUT_B, FULL and EMPTY are combinational from the registered state.
//  - Command priority, evaluated each edge:
//    1. SP_LD: SP<=DIN, DEPTH<=0. SP_INCR/SP_DECR are ignored and do not set ILL.
//    2. SP_INCR and SP_DECR together: SP and DEPTH hold, ILL<=1.
//    3. SP_DECR alone:
//       - not FULL: SP<=SP-1 (wraps 00->FF), DEPTH+1.
//       - FULL: OVF<=1; the SP update follows the CONFIGURATION rules.
//    4. SP_INCR alone:
//       - not EMPTY: SP<=SP+1 (wraps FF->00), DEPTH-1.
//       - EMPTY: UDF<=1; the SP update follows the CONFIGURATION rules.
//    5. No command: everything holds.
//  - DEPTH never wraps. It saturates at 0 and at 2**WIDTH in every configuration.
//  - Flags:
//    - OVF, UDF and ILL are set only by the events listed above.
//    - They clear only on CLR_ERR or reset.
//    - If CLR_ERR and a setting event occur in the same cycle, set wins.
//  - All SP arithmetic is modulo 2**WIDTH. DEPTH is unsigned, WIDTH+1 bits.
// CONFIGURATION
//  - Macro SP_GUARD_EN.
//  - Defined: a push while FULL and a pop while EMPTY are suppressed. SP holds and
//    DEPTH holds; only the flag sets. The stack cannot corrupt itself.
//  - Undefined: SP moves and wraps anyway. DEPTH still saturates and the flag still
//    sets. This matches the original RAT behaviour, where software owns the stack.
// TESTING
//  - Reset: RST_N low -> SP_OUT=00, SP_OUT_B=FF, DEPTH=0, EMPTY=1, all flags 0.
//  - Push then pop from reset: SP_DECR for 1 cycle -> SP_OUT=FF, SP_OUT_B=FE,
//    DEPTH=1. Then SP_INCR for 1 cycle -> SP_OUT=00, EMPTY=1.
//  - Load overrides commands: SP_LD=1, DIN=80, SP_INCR=1 -> SP_OUT=80, DEPTH=0,
//    ILL=0. Then one pop -> UDF=1. With SP_GUARD_EN SP_OUT stays 80; without it
//    SP_OUT=81.
//  - Simultaneous push and pop: SP_INCR=SP_DECR=1 at SP=40, DEPTH=3 -> SP=40,
//    DEPTH=3 hold, ILL=1. Then CLR_ERR -> ILL=0.
//  - Fill and overflow: 256 pushes from reset -> FULL=1, SP_OUT=00. A 257th push
//    -> OVF=1, DEPTH=256. With SP_GUARD_EN SP_OUT=00; without it SP_OUT=FF.
//  - Reset mid-sequence: drop RST_N asynchronously during a push burst (between
//    edges) -> all outputs at their reset values before the next CLK edge.

Source files
------------

// File: rtl/stack_pointer_unit_if.sv
// Command/status bundle between the RAT control unit and the stack pointer unit.
// The master issues push/pop/load commands; the slave returns SP and stack status.
interface stack_pointer_unit_if #(
  parameter int WIDTH = 8
);
  logic             sp_ld;
  logic             sp_decr;
  logic             sp_incr;
  logic             clr_err;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] sp_out;
  logic [WIDTH-1:0] sp_out_b;
  logic [WIDTH:0]   depth;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             udf;
  logic             ill;

  modport master (
    output sp_ld, sp_decr, sp_incr, clr_err, din,
    input  sp_out, sp_out_b, depth, full, empty, ovf, udf, ill
  );

  modport slave (
    input  sp_ld, sp_decr, sp_incr, clr_err, din,
    output sp_out, sp_out_b, depth, full, empty, ovf, udf, ill
  );
endinterface

// File: rtl/stack_pointer_unit.sv
// RAT MCU stack pointer with depth tracking and sticky overflow/underflow/illegal flags.
// Define SP_GUARD_EN to suppress SP movement on a push while full or a pop while empty.
module stack_pointer_unit #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  stack_pointer_unit_if.slave io_sp
);

  localparam logic [WIDTH:0] DEPTH_MAX = {1'b1, {WIDTH{1'b0}}};

  logic [WIDTH-1:0] r_sp;
  logic [WIDTH:0]   r_depth;
  logic             r_ovf;
  logic             r_udf;
  logic             r_ill;

  logic [WIDTH-1:0] w_sp_dec;
  logic [WIDTH-1:0] w_sp_inc;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_sp_next;
  logic [WIDTH:0]   w_depth_next;
  logic             w_ovf_next;
  logic             w_udf_next;
  logic             w_ill_next;

  assign w_sp_dec = r_sp - WIDTH'(1);
  assign w_sp_inc = r_sp + WIDTH'(1);
  assign w_full   = (r_depth == DEPTH_MAX);
  assign w_empty  = (r_depth == '0);

  // Flags are cleared first so that a same-cycle setting event overrides CLR_ERR.
  always_comb begin
    w_sp_next    = r_sp;
    w_depth_next = r_depth;
    w_ovf_next   = r_ovf & ~io_sp.clr_err;
    w_udf_next   = r_udf & ~io_sp.clr_err;
    w_ill_next   = r_ill & ~io_sp.clr_err;

    if (io_sp.sp_ld) begin
      w_sp_next    = io_sp.din;
      w_depth_next = '0;
    end else if (io_sp.sp_incr && io_sp.sp_decr) begin
      w_ill_next = 1'b1;
    end else if (io_sp.sp_decr) begin
      if (!w_full) begin
        w_sp_next    = w_sp_dec;
        w_depth_next = r_depth + (WIDTH+1)'(1);
      end else begin
        w_ovf_next = 1'b1;
`ifdef SP_GUARD_EN
        w_sp_next  = r_sp;
`else
        w_sp_next  = w_sp_dec;
`endif
      end
    end else if (io_sp.sp_incr) begin
      if (!w_empty) begin
        w_sp_next    = w_sp_inc;
        w_depth_next = r_depth - (WIDTH+1)'(1);
      end else begin
        w_udf_next = 1'b1;
`ifdef SP_GUARD_EN
        w_sp_next  = r_sp;
`else
        w_sp_next  = w_sp_inc;
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sp    <= RESET_VAL;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_sp    <= w_sp_next;
      r_depth <= w_depth_next;
      r_ovf   <= w_ovf_next;
      r_udf   <= w_udf_next;
      r_ill   <= w_ill_next;
    end
  end

  assign io_sp.sp_out   = r_sp;
  assign io_sp.sp_out_b = w_sp_dec;
  assign io_sp.depth    = r_depth;
  assign io_sp.full     = w_full;
  assign io_sp.empty    = w_empty;
  assign io_sp.ovf      = r_ovf;
  assign io_sp.udf      = r_udf;
  assign io_sp.ill      = r_ill;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed bench for stack_pointer_unit; expectations follow SP_GUARD_EN when defined.
module tb_stack_pointer_unit;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  stack_pointer_unit_if #(.WIDTH(8)) sp_if ();

  stack_pointer_unit #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_sp   (sp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive one command, let one rising edge sample it, then idle.
  task automatic cmd(input logic ld, input logic [7:0] d, input logic inc,
                     input logic dec, input logic clr);
    sp_if.sp_ld   = ld;
    sp_if.din     = d;
    sp_if.sp_incr = inc;
    sp_if.sp_decr = dec;
    sp_if.clr_err = clr;
    @(posedge clk);
    @(negedge clk);
    sp_if.sp_ld   = 1'b0;
    sp_if.din     = 8'h00;
    sp_if.sp_incr = 1'b0;
    sp_if.sp_decr = 1'b0;
    sp_if.clr_err = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sp"},    sp_if.sp_out,   32'h00);
    check({tag, "_spb"},   sp_if.sp_out_b, 32'hFF);
    check({tag, "_depth"}, sp_if.depth,    32'd0);
    check({tag, "_empty"}, sp_if.empty,    32'd1);
    check({tag, "_full"},  sp_if.full,     32'd0);
    check({tag, "_ovf"},   sp_if.ovf,      32'd0);
    check({tag, "_udf"},   sp_if.udf,      32'd0);
    check({tag, "_ill"},   sp_if.ill,      32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    sp_if.sp_ld   = 1'b0;
    sp_if.din     = 8'h00;
    sp_if.sp_incr = 1'b0;
    sp_if.sp_decr = 1'b0;
    sp_if.clr_err = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset released");

    cmd(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("push1_sp",    sp_if.sp_out,   32'hFF);
    check("push1_spb",   sp_if.sp_out_b, 32'hFE);
    check("push1_depth", sp_if.depth,    32'd1);
    check("push1_empty", sp_if.empty,    32'd0);
    $display("[TB] push from reset: sp=%0h depth=%0d", sp_if.sp_out, sp_if.depth);

    cmd(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("pop1_sp",    sp_if.sp_out, 32'h00);
    check("pop1_depth", sp_if.depth,  32'd0);
    check("pop1_empty", sp_if.empty,  32'd1);
    $display("[TB] pop back: sp=%0h depth=%0d", sp_if.sp_out, sp_if.depth);

    cmd(1'b1, 8'h80, 1'b1, 1'b0, 1'b0);
    check("ld_sp",    sp_if.sp_out, 32'h80);
    check("ld_depth", sp_if.depth,  32'd0);
    check("ld_ill",   sp_if.ill,    32'd0);
    $display("[TB] load 80 with incr: sp=%0h", sp_if.sp_out);

    cmd(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("udf_flag",  sp_if.udf,   32'd1);
    check("udf_depth", sp_if.depth, 32'd0);
`ifdef SP_GUARD_EN
    check("udf_sp", sp_if.sp_out, 32'h80);
`else
    check("udf_sp", sp_if.sp_out, 32'h81);
`endif
    $display("[TB] pop while empty: sp=%0h udf=%0b", sp_if.sp_out, sp_if.udf);

    cmd(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("udf_clr", sp_if.udf, 32'd0);
    $display("[TB] clr_err: udf=%0b", sp_if.udf);

    cmd(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    repeat (3) cmd(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("pre_ill_sp",    sp_if.sp_out, 32'h40);
    check("pre_ill_depth", sp_if.depth,  32'd3);
    cmd(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    check("ill_sp",    sp_if.sp_out, 32'h40);
    check("ill_depth", sp_if.depth,  32'd3);
    check("ill_flag",  sp_if.ill,    32'd1);
    $display("[TB] incr+decr: sp=%0h depth=%0d ill=%0b", sp_if.sp_out, sp_if.depth, sp_if.ill);

    cmd(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ill_clr", sp_if.ill, 32'd0);
    $display("[TB] clr_err: ill=%0b", sp_if.ill);

    cmd(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    check("set_wins_ill", sp_if.ill, 32'd1);
    cmd(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("set_wins_clr", sp_if.ill, 32'd0);
    $display("[TB] clr_err with ill event: set wins, then cleared");

    rst_n = 1'b0;
    #1;
    check("rst2_sp", sp_if.sp_out, 32'h00);
    check("rst2_depth", sp_if.depth, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 256; i++) cmd(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("fill_full",  sp_if.full,   32'd1);
    check("fill_empty", sp_if.empty,  32'd0);
    check("fill_sp",    sp_if.sp_out, 32'h00);
    check("fill_depth", sp_if.depth,  32'd256);
    check("fill_ovf",   sp_if.ovf,    32'd0);
    $display("[TB] 256 pushes: sp=%0h depth=%0d full=%0b", sp_if.sp_out, sp_if.depth, sp_if.full);

    cmd(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ovf_flag",  sp_if.ovf,   32'd1);
    check("ovf_depth", sp_if.depth, 32'd256);
`ifdef SP_GUARD_EN
    check("ovf_sp", sp_if.sp_out, 32'h00);
`else
    check("ovf_sp", sp_if.sp_out, 32'hFF);
`endif
    $display("[TB] 257th push: sp=%0h depth=%0d ovf=%0b", sp_if.sp_out, sp_if.depth, sp_if.ovf);

    cmd(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("pop_full_depth", sp_if.depth, 32'd255);
    check("pop_full_full",  sp_if.full,  32'd0);
    check("pop_full_ovf",   sp_if.ovf,   32'd1);
`ifdef SP_GUARD_EN
    check("pop_full_sp", sp_if.sp_out, 32'h01);
`else
    check("pop_full_sp", sp_if.sp_out, 32'h00);
`endif
    $display("[TB] pop after full: sp=%0h depth=%0d", sp_if.sp_out, sp_if.depth);

    sp_if.sp_decr = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    $display("[TB] async reset mid-burst: sp=%0h depth=%0d", sp_if.sp_out, sp_if.depth);
    sp_if.sp_decr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
